// File: rtl/overlay_axis_pattern_pkg.sv
// overlay_axis_pattern_pkg: register map, bit indices and FSM state shared by the pattern transmitter
package overlay_axis_pattern_pkg;
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_SEED   = 2'd1;
  localparam logic [1:0] REG_LEN    = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;
  localparam int CTRL_START   = 0;
  localparam int CTRL_REPEAT  = 1;
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_LENERR  = 2;
  localparam int STAT_CNT_LSB = 16;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old, input logic [31:0] data,
                                              input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (strb[i]) r[8*i+:8] = data[8*i+:8];
    return r;
  endfunction
endpackage

// File: rtl/overlay_axil_regs.sv
// overlay_axil_regs: AXI4-Lite slave handshake and control/status register file
module overlay_axil_regs
  import overlay_axis_pattern_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int C_LEN_WIDTH        = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   awaddr_i,
  input  logic                            awvalid_i,
  output logic                            awready_o,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   wdata_i,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb_i,
  input  logic                            wvalid_i,
  output logic                            wready_o,
  output logic                            bvalid_o,
  input  logic                            bready_i,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   araddr_i,
  input  logic                            arvalid_i,
  output logic                            arready_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   rdata_o,
  output logic                            rvalid_o,
  input  logic                            rready_i,
  output logic                            start_o,
  output logic                            repeat_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   seed_o,
  output logic [C_LEN_WIDTH-1:0]          len_o,
  input  logic                            busy_i,
  input  logic                            done_i,
  input  logic                            lenerr_i,
  input  logic [15:0]                     pkt_cnt_i
);
  logic aw_ready_q, aw_ready_d, b_valid_q, b_valid_d, ar_ready_q, ar_ready_d, r_valid_q, r_valid_d;
  logic repeat_q, repeat_d, wr_en, rd_en, ctrl_wr;
  logic [C_S_AXI_DATA_WIDTH-1:0] seed_q, seed_d, rdata_q, rdata_d, status, ctrl_rd, len_wr;
  logic [C_LEN_WIDTH-1:0] len_q, len_d;
  logic unused_addr;
  assign unused_addr = ^{awaddr_i[1:0], araddr_i[1:0]};
  always_comb begin
    wr_en      = aw_ready_q & awvalid_i & wvalid_i;
    rd_en      = ar_ready_q & arvalid_i;
    ctrl_wr    = wr_en && awaddr_i[3:2] == REG_CTRL && wstrb_i[0];
    start_o    = ctrl_wr && wdata_i[CTRL_START];
    len_wr     = apply_wstrb(C_S_AXI_DATA_WIDTH'(len_q), wdata_i, wstrb_i);
    seed_d     = wr_en && awaddr_i[3:2] == REG_SEED ? apply_wstrb(seed_q, wdata_i, wstrb_i) : seed_q;
    len_d      = wr_en && awaddr_i[3:2] == REG_LEN ? len_wr[C_LEN_WIDTH-1:0] : len_q;
    repeat_d   = ctrl_wr ? wdata_i[CTRL_REPEAT] : repeat_q;
    // Ready is registered and self-clearing, so it is high for exactly one cycle per transfer
    aw_ready_d = awvalid_i & wvalid_i & ~b_valid_q & ~aw_ready_q;
    b_valid_d  = wr_en | (b_valid_q & ~bready_i);
    ar_ready_d = arvalid_i & ~r_valid_q & ~ar_ready_q;
    r_valid_d  = rd_en | (r_valid_q & ~rready_i);
    status                           = '0;
    status[STAT_BUSY]                = busy_i;
    status[STAT_DONE]                = done_i;
    status[STAT_LENERR]              = lenerr_i;
    status[STAT_CNT_LSB+:16]         = pkt_cnt_i;
    ctrl_rd                          = '0;
    ctrl_rd[CTRL_REPEAT]             = repeat_q;
    rdata_d = !rd_en ? rdata_q :
              araddr_i[3:2] == REG_CTRL ? ctrl_rd :
              araddr_i[3:2] == REG_SEED ? seed_q :
              araddr_i[3:2] == REG_LEN  ? C_S_AXI_DATA_WIDTH'(len_q) : status;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_ready_q <= 1'b0;
      b_valid_q  <= 1'b0;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      rdata_q    <= '0;
      repeat_q   <= 1'b0;
      seed_q     <= '0;
      len_q      <= '0;
    end else begin
      aw_ready_q <= aw_ready_d;
      b_valid_q  <= b_valid_d;
      ar_ready_q <= ar_ready_d;
      r_valid_q  <= r_valid_d;
      rdata_q    <= rdata_d;
      repeat_q   <= repeat_d;
      seed_q     <= seed_d;
      len_q      <= len_d;
    end
  end
  assign awready_o = aw_ready_q;
  assign wready_o  = aw_ready_q;
  assign bvalid_o  = b_valid_q;
  assign arready_o = ar_ready_q;
  assign rvalid_o  = r_valid_q;
  assign rdata_o   = rdata_q;
  assign repeat_o  = repeat_q;
  assign seed_o    = seed_q;
  assign len_o     = len_q;
endmodule

// File: rtl/overlay_axis_pattern_tx.sv
// overlay_axis_pattern_tx: AXI-Stream source of incrementing-word packets under AXI-Lite control
module overlay_axis_pattern_tx
  import overlay_axis_pattern_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH   = 32,
  parameter int C_S_AXI_ADDR_WIDTH   = 4,
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int C_LEN_WIDTH          = 16
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TKEEP,
  output logic                              M_AXIS_TLAST,
  output logic                              M_AXIS_TVALID,
  input  logic                              M_AXIS_TREADY
);
  state_e st_q, st_d;
  logic [C_M_AXIS_TDATA_WIDTH-1:0] base_q, base_d;
  logic [C_LEN_WIDTH-1:0] blen_q, blen_d, idx_q, idx_d, len;
  logic [C_S_AXI_DATA_WIDTH-1:0] seed;
  logic [15:0] cnt_q, cnt_d;
  logic done_q, done_d, lenerr_q, lenerr_d, start, rep, fire, last;
  overlay_axil_regs #(
    .C_S_AXI_DATA_WIDTH(C_S_AXI_DATA_WIDTH),
    .C_S_AXI_ADDR_WIDTH(C_S_AXI_ADDR_WIDTH),
    .C_LEN_WIDTH       (C_LEN_WIDTH)
  ) u_regs (
    .clk      (ACLK),
    .rst      (ARESET),
    .awaddr_i (S_AXI_AWADDR),
    .awvalid_i(S_AXI_AWVALID),
    .awready_o(S_AXI_AWREADY),
    .wdata_i  (S_AXI_WDATA),
    .wstrb_i  (S_AXI_WSTRB),
    .wvalid_i (S_AXI_WVALID),
    .wready_o (S_AXI_WREADY),
    .bvalid_o (S_AXI_BVALID),
    .bready_i (S_AXI_BREADY),
    .araddr_i (S_AXI_ARADDR),
    .arvalid_i(S_AXI_ARVALID),
    .arready_o(S_AXI_ARREADY),
    .rdata_o  (S_AXI_RDATA),
    .rvalid_o (S_AXI_RVALID),
    .rready_i (S_AXI_RREADY),
    .start_o  (start),
    .repeat_o (rep),
    .seed_o   (seed),
    .len_o    (len),
    .busy_i   (st_q == ST_RUN),
    .done_i   (done_q),
    .lenerr_i (lenerr_q),
    .pkt_cnt_i(cnt_q)
  );
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign M_AXIS_TKEEP  = '1;
  assign M_AXIS_TVALID = st_q == ST_RUN;
  assign M_AXIS_TDATA  = base_q + C_M_AXIS_TDATA_WIDTH'(idx_q);
  assign M_AXIS_TLAST  = M_AXIS_TVALID && last;
  assign fire          = M_AXIS_TVALID && M_AXIS_TREADY;
  assign last          = idx_q == blen_q - 1'b1;
  always_comb begin
    st_d     = st_q;
    base_d   = base_q;
    blen_d   = blen_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    lenerr_d = lenerr_q;
    if (st_q == ST_IDLE) begin
      if (start) begin
        done_d   = 1'b0;
        lenerr_d = len == '0;
        if (len != '0) begin
          st_d   = ST_RUN;
          base_d = C_M_AXIS_TDATA_WIDTH'(seed);
          blen_d = len;
          idx_d  = '0;
        end
      end
    end else if (fire) begin
      idx_d = idx_q + 1'b1;
      if (last) begin
        cnt_d  = cnt_q + 1'b1;
        done_d = 1'b1;
        // Repeat reloads live SEED/LEN in the same cycle so TVALID never bubbles
        if (!rep) st_d = ST_IDLE;
        else if (len == '0) begin
          lenerr_d = 1'b1;
          st_d     = ST_IDLE;
        end else begin
          base_d = C_M_AXIS_TDATA_WIDTH'(seed);
          blen_d = len;
          idx_d  = '0;
        end
      end
    end
  end
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      st_q     <= ST_IDLE;
      base_q   <= '0;
      blen_q   <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      lenerr_q <= 1'b0;
    end else begin
      st_q     <= st_d;
      base_q   <= base_d;
      blen_q   <= blen_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      lenerr_q <= lenerr_d;
    end
  end
endmodule

// File: tb/tb_overlay_axis_pattern_tx.sv
// tb_overlay_axis_pattern_tx: randomized packet bench checking observed beats against a per-packet arithmetic model
module tb_overlay_axis_pattern_tx;
  logic clk, rst;
  logic [3:0] awaddr, araddr, wstrb, tkeep;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata, tdata;
  logic [1:0] bresp, rresp;
  logic tlast, tvalid, tready;
  int n_vec = 0, n_err = 0, cyc = 0, rdy_mode = 0;
  logic [15:0] exp_cnt = '0;
  logic [31:0] gd[$];
  logic gl[$];
  int gc[$];

  overlay_axis_pattern_tx dut (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .M_AXIS_TDATA(tdata), .M_AXIS_TKEEP(tkeep), .M_AXIS_TLAST(tlast),
    .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(tready)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // TREADY: 0 = always ready, 1 = random, 2 = pattern 1,0,0
  initial begin
    int pat = 0;
    tready = 0;
    forever begin
      @(posedge clk); #1;
      tready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom_range(0, 1)) : (pat % 3 == 0);
      pat++;
    end
  end

  // Stream monitor: records accepted beats and checks hold-while-stalled
  initial begin
    logic ps, pl;
    logic [31:0] pd;
    ps = 0; pl = 0; pd = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) ps = 0;
      else begin
        if (ps) begin
          chk("hold_valid", tvalid, 1);
          chk("hold_data", tdata, pd);
          chk("hold_last", tlast, pl);
        end
        if (tvalid && tready) begin
          gd.push_back(tdata);
          gl.push_back(tlast);
          gc.push_back(cyc);
        end
        ps = tvalid && !tready;
        pd = tdata;
        pl = tlast;
      end
    end
  end

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; n = 0;
    while (!(awready && wready) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("aw_wait", n < 50, 1);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    chk("bvalid", bvalid, 1);
    chk("bresp", bresp, 0);
    repeat ($urandom_range(0, 1)) begin
      @(posedge clk); #1;
      chk("bvalid_hold", bvalid, 1);
    end
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    chk("bvalid_clr", bvalid, 0);
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int n;
    @(posedge clk); #1;
    araddr = a; arvalid = 1; n = 0;
    while (!arready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("ar_wait", n < 50, 1);
    @(posedge clk); #1;
    arvalid = 0;
    chk("rvalid", rvalid, 1);
    chk("rresp", rresp, 0);
    d = rdata;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
      chk("rvalid_hold", rvalid, 1);
      chk("rdata_hold", rdata, d);
    end
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
    chk("rvalid_clr", rvalid, 0);
  endtask

  function automatic logic [31:0] status_exp(input logic busy, done, lenerr);
    return {exp_cnt, 13'b0, lenerr, done, busy};
  endfunction

  task automatic run_pkt(input logic [31:0] s, input int len, input int mode, input bit mid);
    int n;
    logic [31:0] st, e;
    rdy_mode = mode;
    gd.delete(); gl.delete(); gc.delete();
    axi_write(4'h4, s, 4'hF);
    axi_write(4'h8, 32'(len), 4'hF);
    axi_write(4'h0, 32'h1, 4'hF);
    if (mid) begin
      axi_write(4'h4, $urandom, 4'hF);
      axi_write(4'h8, $urandom_range(1, 5), 4'hF);
      axi_write(4'h0, 32'h1, 4'hF);
    end
    n = 0;
    while (gd.size() < len && n < 40 * len + 100) begin
      @(posedge clk); n++;
    end
    repeat (6) @(posedge clk);
    chk("pkt_beats", gd.size(), len);
    for (int i = 0; i < gd.size() && i < len; i++) begin
      e = s + i;
      chk("pkt_data", gd[i], e);
      chk("pkt_last", gl[i], i == len - 1);
    end
    exp_cnt++;
    axi_read(4'hC, st);
    chk("pkt_status", st, status_exp(0, 1, 0));
  endtask

  initial begin
    logic [31:0] r, s;
    int n;
    rst = 1; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    araddr = 0; arvalid = 0; rready = 0;
    #23;
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_arready", arready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tlast", tlast, 0);
    chk("tkeep", tkeep, 4'hF);
    @(posedge clk); #1 rst = 0;
    for (int a = 0; a < 16; a += 4) begin
      axi_read(4'(a), r);
      chk("rst_reg", r, 0);
    end
    // LEN==0 start: no beats, LENERR only
    gd.delete();
    axi_write(4'h0, 32'h1, 4'hF);
    repeat (8) @(posedge clk);
    chk("len0_beats", gd.size(), 0);
    axi_read(4'hC, r);
    chk("len0_status", r, status_exp(0, 0, 1));
    run_pkt($urandom, 2, 1, 0);
    run_pkt(32'h0101FFFF, 4, 0, 0);
    run_pkt(32'h10, 3, 2, 0);
    for (int k = 0; k < 5; k++) run_pkt($urandom, $urandom_range(1, 10), $urandom_range(0, 2), 0);
    run_pkt($urandom, 12, 2, 1);
    // REPEAT with a wrapping seed: back-to-back packets, then drain on clear
    rdy_mode = 0;
    gd.delete(); gl.delete(); gc.delete();
    axi_write(4'h4, 32'hFFFFFFFF, 4'hF);
    axi_write(4'h8, 32'h2, 4'hF);
    axi_write(4'h0, 32'h3, 4'hF);
    repeat (20) @(posedge clk);
    axi_write(4'h0, 32'h0, 4'hF);
    repeat (10) @(posedge clk);
    #1;
    chk("rep_tvalid_low", tvalid, 0);
    n = gd.size();
    chk("rep_even", n % 2, 0);
    chk("rep_many", n >= 10, 1);
    for (int i = 0; i < n; i++) begin
      s = 32'hFFFFFFFF + 32'(i % 2);
      chk("rep_data", gd[i], s);
      chk("rep_last", gl[i], i % 2 == 1);
      chk("rep_nobubble", gc[i] - gc[0], i);
    end
    exp_cnt += 16'(n / 2);
    axi_read(4'hC, r);
    chk("rep_status", r, status_exp(0, 1, 0));
    // Byte strobes, read-only STATUS, CTRL readback
    axi_write(4'h4, 32'h0, 4'hF);
    axi_write(4'h4, 32'hABCD0001, 4'b0011);
    axi_read(4'h4, r);
    chk("wstrb_seed", r, 32'h00000001);
    axi_write(4'h8, 32'h12345678, 4'hF);
    axi_read(4'h8, r);
    chk("len_trunc", r, 32'h00005678);
    axi_write(4'h8, 32'hAAAABBCC, 4'b0010);
    axi_read(4'h8, r);
    chk("wstrb_len", r, 32'h0000BB78);
    axi_write(4'hC, 32'hFFFFFFFF, 4'hF);
    axi_read(4'hC, r);
    chk("status_ro", r, status_exp(0, 1, 0));
    axi_write(4'h0, 32'h2, 4'hF);
    axi_read(4'h0, r);
    chk("ctrl_repeat_rd", r, 32'h2);
    chk("ctrl_nostart", tvalid, 0);
    axi_write(4'h0, 32'h0, 4'hF);
    axi_read(4'h0, r);
    chk("ctrl_clr_rd", r, 32'h0);
    // Async reset mid-packet
    rdy_mode = 0;
    gd.delete(); gl.delete(); gc.delete();
    s = $urandom;
    axi_write(4'h4, s, 4'hF);
    axi_write(4'h8, 32'h8, 4'hF);
    axi_write(4'h0, 32'h1, 4'hF);
    n = 0;
    while (gd.size() < 1 && n < 100) begin
      @(posedge clk); #2; n++;
    end
    chk("rst_wait", n < 100, 1);
    rst = 1;
    #1;
    chk("arst_tvalid", tvalid, 0);
    chk("arst_tlast", tlast, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("arst_beats", gd.size(), 1);
    chk("arst_beat0", gd[0], s);
    exp_cnt = '0;
    for (int a = 0; a < 16; a += 4) begin
      axi_read(4'(a), r);
      chk("arst_reg", r, 0);
    end
    run_pkt($urandom, 3, 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
